// File: rtl/wb_regfile_pkg.sv
// Shared types and widths for the writeback register file.
package wb_regfile_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned NREG = 32;
    localparam int unsigned IDXW = $clog2(NREG);

    typedef logic [IDXW-1:0] reg_idx_t;
    typedef logic [XLEN-1:0] word_t;

    // Memory-stage pipe payload; the writeback beat reuses these fields.
    typedef struct packed {
        logic     valid;
        logic     wen;
        reg_idx_t rd;
        word_t    data;
    } mem_pipe_t;

    // A beat updates architectural state only when it writes a non-x0 register.
    function automatic logic wb_qualifies(input mem_pipe_t beat);
        return beat.valid && beat.wen && (beat.rd != '0);
    endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register pending-write counters with issue back-pressure and busy flags.
// Optional macro WB_BYPASS_EN: a same-cycle writeback that retires the last
// pending write to a read register clears its busy flag in that cycle.
module wb_scoreboard #(
    parameter int unsigned NREG    = 32,
    parameter int unsigned MAXPEND = 3,
    parameter int unsigned IW      = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          issue_valid_i,
    input  logic          issue_wen_i,
    input  logic [IW-1:0] issue_rd_i,
    input  logic          dec_i,
    input  logic [IW-1:0] dec_rd_i,
    input  logic          flush_i,
    input  logic [IW-1:0] rs1_i,
    input  logic [IW-1:0] rs2_i,
    output logic          issue_ready_o,
    output logic          busy1_o,
    output logic          busy2_o
);
    import wb_regfile_pkg::*;

    localparam int unsigned CW = $clog2(MAXPEND + 1);
    localparam logic [CW-1:0] CMAX = CW'(MAXPEND);

    logic [CW-1:0] cnt_q [NREG];
    logic [CW-1:0] cnt_d [NREG];
    logic          inc;
    logic          same_idx;

    // Accept/refuse the issue and derive the increment strobe.
    always_comb begin
        issue_ready_o = 1'b1;
        same_idx      = dec_i && (dec_rd_i == issue_rd_i);
        if (issue_wen_i && (issue_rd_i != '0) && (cnt_q[issue_rd_i] == CMAX) && !same_idx) begin
            issue_ready_o = 1'b0;
        end
        inc = issue_valid_i && issue_ready_o && issue_wen_i && (issue_rd_i != '0);
    end

    // Next counter values: flush wins, inc+dec on one index cancel, dec saturates at 0.
    always_comb begin
        cnt_d = cnt_q;
        if (flush_i) begin
            cnt_d = '{default: '0};
        end else begin
            if (inc && !same_idx) begin
                cnt_d[issue_rd_i] = cnt_q[issue_rd_i] + CW'(1);
            end
            if (dec_i && !(inc && same_idx) && (cnt_q[dec_rd_i] != '0)) begin
                cnt_d[dec_rd_i] = cnt_q[dec_rd_i] - CW'(1);
            end
        end
        cnt_d[0] = '0;
    end

    // Counter storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '{default: '0};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Busy flags for the two decode read ports.
    always_comb begin
        busy1_o = (cnt_q[rs1_i] != '0);
        busy2_o = (cnt_q[rs2_i] != '0);
`ifdef WB_BYPASS_EN
        if (dec_i && (dec_rd_i == rs1_i) && (cnt_q[rs1_i] == CW'(1)) && !(inc && (issue_rd_i == rs1_i))) begin
            busy1_o = 1'b0;
        end
        if (dec_i && (dec_rd_i == rs2_i) && (cnt_q[rs2_i] == CW'(1)) && !(inc && (issue_rd_i == rs2_i))) begin
            busy2_o = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/wb_regfile.sv
// Architectural register file written from MEM/WB with pending-write tracking.
// Optional macro WB_BYPASS_EN: forward a same-cycle writeback to the read ports.
module wb_regfile #(
    parameter int unsigned XLEN    = wb_regfile_pkg::XLEN,
    parameter int unsigned NREG    = wb_regfile_pkg::NREG,
    parameter int unsigned MAXPEND = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wb_valid,
    input  logic            wb_wen,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            issue_valid,
    input  logic            issue_wen,
    input  logic [4:0]      issue_rd,
    output logic            issue_ready,
    input  logic            flush,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    output logic            busy1,
    output logic            busy2
);
    import wb_regfile_pkg::*;

    localparam int unsigned IW = $clog2(NREG);

    mem_pipe_t       wb_beat;
    logic            wb_fire;
    logic [IW-1:0]   wb_idx;
    logic [XLEN-1:0] wb_word;
    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];

    // Pack the writeback ports into the shared memory-stage payload.
    always_comb begin
        wb_beat.valid = wb_valid;
        wb_beat.wen   = wb_wen;
        wb_beat.rd    = reg_idx_t'(wb_rd);
        wb_beat.data  = word_t'(wb_data);
    end

    assign wb_fire = wb_qualifies(wb_beat) && !reset;
    assign wb_idx  = IW'(wb_beat.rd);
    assign wb_word = XLEN'(wb_beat.data);

    // Next array contents; x0 is pinned to zero.
    always_comb begin
        regs_d = regs_q;
        if (wb_fire) begin
            regs_d[wb_idx] = wb_word;
        end
        regs_d[0] = '0;
    end

    // Register array storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // Combinational read ports, optionally forwarding the in-flight writeback.
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (rs1 != 5'd0) rdata1 = regs_q[IW'(rs1)];
        if (rs2 != 5'd0) rdata2 = regs_q[IW'(rs2)];
`ifdef WB_BYPASS_EN
        if (wb_fire && (wb_rd == rs1) && (rs1 != 5'd0)) rdata1 = wb_word;
        if (wb_fire && (wb_rd == rs2) && (rs2 != 5'd0)) rdata2 = wb_word;
`endif
    end

    wb_scoreboard #(
        .NREG    (NREG),
        .MAXPEND (MAXPEND),
        .IW      (IW)
    ) u_scoreboard (
        .clk           (clk),
        .reset         (reset),
        .issue_valid_i (issue_valid),
        .issue_wen_i   (issue_wen),
        .issue_rd_i    (IW'(issue_rd)),
        .dec_i         (wb_fire),
        .dec_rd_i      (wb_idx),
        .flush_i       (flush),
        .rs1_i         (IW'(rs1)),
        .rs2_i         (IW'(rs2)),
        .issue_ready_o (issue_ready),
        .busy1_o       (busy1),
        .busy2_o       (busy2)
    );

endmodule
